// File: rtl/xy_route_demux_if.sv
// xy_route_demux_if: flit bus between the per-output arbiter, the XY route
// demultiplexer and the per-direction output links.
// Ports (signals):
//   in_tdata/in_tid/in_tdest/in_tuser  flit from the arbiter
//   in_valid / in_ready                input handshake
//   target_x / target_y                header destination coordinates
//   out_tdata/out_tid/out_tdest/out_tuser [CHANNEL_NUMBER]  per-port flit
//   out_valid / out_ready [CHANNEL_NUMBER]                  per-port handshake
//   proto_err                          one-cycle protocol violation pulse
// Modports: master = arbiter/link side, slave = demux side.
interface xy_route_demux_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int DEST_WIDTH     = 4,
    parameter int USER_WIDTH     = 4,
    parameter int CHANNEL_NUMBER = 5,
    parameter int XW             = 2,
    parameter int YW             = 2
);
    logic [DATA_WIDTH-1:0]     in_tdata;
    logic [ID_WIDTH-1:0]       in_tid;
    logic [DEST_WIDTH-1:0]     in_tdest;
    logic [USER_WIDTH-1:0]     in_tuser;
    logic                      in_valid;
    logic                      in_ready;
    logic [XW-1:0]             target_x;
    logic [YW-1:0]             target_y;

    logic [DATA_WIDTH-1:0]     out_tdata [CHANNEL_NUMBER];
    logic [ID_WIDTH-1:0]       out_tid   [CHANNEL_NUMBER];
    logic [DEST_WIDTH-1:0]     out_tdest [CHANNEL_NUMBER];
    logic [USER_WIDTH-1:0]     out_tuser [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] out_valid;
    logic [CHANNEL_NUMBER-1:0] out_ready;
    logic                      proto_err;

    modport master (
        output in_tdata, in_tid, in_tdest, in_tuser, in_valid, target_x, target_y, out_ready,
        input  in_ready, out_tdata, out_tid, out_tdest, out_tuser, out_valid, proto_err
    );

    modport slave (
        input  in_tdata, in_tid, in_tdest, in_tuser, in_valid, target_x, target_y, out_ready,
        output in_ready, out_tdata, out_tid, out_tdest, out_tuser, out_valid, proto_err
    );
endinterface

// File: rtl/xy_route_demux.sv
// xy_route_demux: steers whole packets from the arbiter output to one of
// CHANNEL_NUMBER ports by XY routing. The route is computed on the header
// flit and held for the body beats; each output port has a one-entry slice.
// Ports:
//   clk  clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  xy_route_demux_if.slave (input flit, per-port outputs, proto_err)
//
// state | meaning
// IDLE  | waiting for a header; non-header flits are dropped
// BODY  | forwarding body beats on the latched route, beats_left > 0
module xy_route_demux #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int DEST_WIDTH     = 4,
    parameter int USER_WIDTH     = 4,
    parameter int CHANNEL_NUMBER = 5,
    parameter int MAX_ROUTERS_X  = 4,
    parameter int MAX_ROUTERS_Y  = 4,
    parameter int ROUTER_X       = 0,
    parameter int ROUTER_Y       = 0,
    parameter int ROUTING_HEADER = 1
) (
    input logic              clk,
    input logic              rst,
    xy_route_demux_if.slave  bus
);
    localparam int XW      = $clog2(MAX_ROUTERS_X);
    localparam int YW      = $clog2(MAX_ROUTERS_Y);
    localparam int LEN_LSB = (XW + YW) * 2;
    localparam int PW      = $clog2(CHANNEL_NUMBER);
    localparam int FW      = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    localparam logic [PW-1:0] P_LOCAL = PW'(0);
    localparam logic [PW-1:0] P_NORTH = PW'(1);
    localparam logic [PW-1:0] P_SOUTH = PW'(2);
    localparam logic [PW-1:0] P_EAST  = PW'(3);
    localparam logic [PW-1:0] P_WEST  = PW'(4);

    localparam logic [XW-1:0]       RX  = XW'(ROUTER_X);
    localparam logic [YW-1:0]       RY  = YW'(ROUTER_Y);
    localparam logic [ID_WIDTH-1:0] HDR = ID_WIDTH'(ROUTING_HEADER);

    typedef enum logic [0:0] {IDLE, BODY} state_t;

    state_t                    state_q, state_d;
    logic [7:0]                beats_q, beats_d;
    logic [PW-1:0]             route_q, route_d;
    logic                      perr_q, perr_d;

    logic [CHANNEL_NUMBER-1:0] slot_full;
    logic [FW-1:0]             slot_q [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] load;

    logic                      is_hdr;
    logic [7:0]                hdr_len;
    logic [PW-1:0]             calc;
    logic [PW-1:0]             sel;
    logic                      sel_vld;
    logic                      accept;
    logic [FW-1:0]             in_flit;

    assign is_hdr  = (bus.in_tid == HDR);
    assign hdr_len = bus.in_tdata[LEN_LSB+7:LEN_LSB];
    assign in_flit = {bus.in_tdata, bus.in_tid, bus.in_tdest, bus.in_tuser};

    // X is resolved before Y so packets never turn back into the X dimension.
    always_comb begin
        calc = P_LOCAL;
        if (bus.target_x > RX)      calc = P_EAST;
        else if (bus.target_x < RX) calc = P_WEST;
        else if (bus.target_y < RY) calc = P_NORTH;
        else if (bus.target_y > RY) calc = P_SOUTH;
    end

    // A header always steers by its own coordinates, even mid-packet; a
    // non-header flit in IDLE has no destination and is simply swallowed.
    always_comb begin
        sel     = calc;
        sel_vld = 1'b1;
        if (!is_hdr) begin
            sel     = route_q;
            sel_vld = (state_q == BODY);
        end
    end

    assign bus.in_ready = !sel_vld || !slot_full[sel] || bus.out_ready[sel];
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        load = '0;
        if (accept && sel_vld) load[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beats_q <= 8'd0;
            route_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            route_q <= route_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        route_d = route_q;
        perr_d  = 1'b0;
        if (accept) begin
            if (is_hdr) begin
                route_d = calc;
                beats_d = hdr_len;
                state_d = (hdr_len != 8'd0) ? BODY : IDLE;
                if (state_q == BODY) perr_d = 1'b1;
            end else if (state_q == IDLE) begin
                perr_d = 1'b1;
            end else begin
                beats_d = beats_q - 8'd1;
                if (beats_q == 8'd1) state_d = IDLE;
            end
        end
    end

    // Load wins over drain so a slot being emptied and refilled in the
    // same cycle stays full, giving one flit per cycle per port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < CHANNEL_NUMBER; p++) begin
                slot_full[p] <= 1'b0;
                slot_q[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < CHANNEL_NUMBER; p++) begin
                if (load[p]) begin
                    slot_full[p] <= 1'b1;
                    slot_q[p]    <= in_flit;
                end else if (bus.out_ready[p]) begin
                    slot_full[p] <= 1'b0;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNEL_NUMBER; g++) begin : g_out
            assign bus.out_tdata[g] = slot_q[g][FW-1 -: DATA_WIDTH];
            assign bus.out_tid[g]   = slot_q[g][DEST_WIDTH+USER_WIDTH +: ID_WIDTH];
            assign bus.out_tdest[g] = slot_q[g][USER_WIDTH +: DEST_WIDTH];
            assign bus.out_tuser[g] = slot_q[g][USER_WIDTH-1:0];
        end
    endgenerate

    assign bus.out_valid = slot_full;
    assign bus.proto_err = perr_q;
endmodule
